// File: rtl/mipi_capture_ctrl.sv
// Frame capture controller: arms on start, gates fvi/lvi/dvi/dati to cap_* with 1-cycle latency, checks geometry.
// No backpressure; the source free-runs and anything outside an armed, whole frame is dropped.
module mipi_capture_ctrl #(
  parameter int DATA_WIDTH = 10,
  parameter int TMO_W      = 24
) (
  input  logic                  img_clk,
  input  logic                  resetb,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  continuous,
  input  logic [15:0]           num_lines,
  input  logic [15:0]           num_pix,
  input  logic [TMO_W-1:0]      timeout,
  input  logic                  fvi,
  input  logic                  lvi,
  input  logic                  dvi,
  input  logic [DATA_WIDTH-1:0] dati,
  output logic                  des_enable,
  output logic                  cap_fv,
  output logic                  cap_lv,
  output logic                  cap_dv,
  output logic [DATA_WIDTH-1:0] cap_dat,
  output logic                  busy,
  output logic                  done,
  output logic                  err_lines,
  output logic                  err_pix,
  output logic                  err_tmo,
  output logic [15:0]           frame_cnt
);

  typedef enum logic [1:0] {IDLE, ARM, WAIT_FS, CAPTURE} state_t;

  state_t           state;
  logic             fvi_d, lvi_d;
  logic [15:0]      line_cnt, pix_cnt;
  logic [TMO_W-1:0] wdog;

  logic             fvi_rise, fvi_fall, lvi_rise, lvi_fall;
  logic [15:0]      line_base, pix_base, line_nxt, pix_nxt;
  logic             pix_bad, line_bad, wd_clr, tmo_hit;
  logic [TMO_W-1:0] wd_inc;

  always_comb begin
    fvi_rise  = fvi & ~fvi_d;
    fvi_fall  = ~fvi & fvi_d;
    lvi_rise  = lvi & ~lvi_d;
    lvi_fall  = ~lvi & lvi_d;
    // Counters restart from zero on the fvi-rise cycle that enters CAPTURE.
    line_base = (state == CAPTURE) ? line_cnt : 16'd0;
    pix_base  = (state == CAPTURE) ? pix_cnt : 16'd0;
    line_nxt  = line_base;
    if (lvi_rise && line_base != 16'hFFFF) line_nxt = line_base + 16'd1;
    pix_nxt   = lvi_rise ? 16'd0 : pix_base;
    // A dvi on the lvi-fall cycle still belongs to the line being closed.
    if (dvi && (lvi || lvi_d) && pix_nxt != 16'hFFFF) pix_nxt = pix_nxt + 16'd1;
    pix_bad   = lvi_fall && (pix_nxt != num_pix);
    line_bad  = line_nxt != num_lines;
    wd_clr    = fvi_rise | fvi_fall | lvi_rise | lvi_fall | dvi;
    wd_inc    = wdog + TMO_W'(1);
    tmo_hit   = (timeout != '0) && !wd_clr && (wd_inc == timeout);
  end

  always_ff @(posedge img_clk or negedge resetb) begin
    if (!resetb) begin
      state      <= IDLE;
      fvi_d      <= 1'b0;
      lvi_d      <= 1'b0;
      line_cnt   <= '0;
      pix_cnt    <= '0;
      wdog       <= '0;
      des_enable <= 1'b0;
      cap_fv     <= 1'b0;
      cap_lv     <= 1'b0;
      cap_dv     <= 1'b0;
      cap_dat    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_lines  <= 1'b0;
      err_pix    <= 1'b0;
      err_tmo    <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      fvi_d  <= fvi;
      lvi_d  <= lvi;
      done   <= 1'b0;
      cap_fv <= 1'b0;
      cap_lv <= 1'b0;
      cap_dv <= 1'b0;
      wdog   <= wd_clr ? '0 : wd_inc;
      unique case (state)
        IDLE: begin
          wdog <= '0;
          if (start && !stop) begin
            state      <= ARM;
            des_enable <= 1'b1;
            busy       <= 1'b1;
            err_lines  <= 1'b0;
            err_pix    <= 1'b0;
            err_tmo    <= 1'b0;
          end
        end
        ARM, WAIT_FS, CAPTURE: begin
          if (stop) begin
            state      <= IDLE;
            des_enable <= 1'b0;
            busy       <= 1'b0;
            wdog       <= '0;
          end else if (state == ARM && !fvi) begin
            state <= WAIT_FS;
            wdog  <= '0;
          end else if (state == WAIT_FS && fvi_rise) begin
            state    <= CAPTURE;
            wdog     <= '0;
            line_cnt <= line_nxt;
            pix_cnt  <= pix_nxt;
            cap_fv   <= fvi;
            cap_lv   <= lvi;
            cap_dv   <= dvi;
            cap_dat  <= dati;
          end else if (state == CAPTURE && fvi_fall) begin
            cap_lv    <= lvi;
            cap_dv    <= dvi;
            cap_dat   <= dati;
            line_cnt  <= line_nxt;
            pix_cnt   <= pix_nxt;
            wdog      <= '0;
            done      <= 1'b1;
            frame_cnt <= frame_cnt + 16'd1;
            if (pix_bad) err_pix <= 1'b1;
            if (line_bad) err_lines <= 1'b1;
            if (continuous) begin
              state <= WAIT_FS;
            end else begin
              state      <= IDLE;
              des_enable <= 1'b0;
              busy       <= 1'b0;
            end
          end else if (tmo_hit) begin
            state      <= IDLE;
            des_enable <= 1'b0;
            busy       <= 1'b0;
            err_tmo    <= 1'b1;
            wdog       <= '0;
          end else if (state == CAPTURE) begin
            cap_fv   <= fvi;
            cap_lv   <= lvi;
            cap_dv   <= dvi;
            cap_dat  <= dati;
            line_cnt <= line_nxt;
            pix_cnt  <= pix_nxt;
            if (pix_bad) err_pix <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
